// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding, the default operand width with its counter
// width, and the quotient value returned for a division by zero.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } div_state_t;

  // Default operand width and the width of the bit counter that walks it.
  localparam int DIV_N = 32;
  localparam int CNT_W = $clog2(DIV_N);

  // Quotient reported when the divisor is zero (all ones, i.e. -1 when signed).
  localparam logic [DIV_N-1:0] DBZ_QUOTIENT = {DIV_N{1'b1}};

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none; the caller sequences the steps.
// Ports: remIn (partial remainder), bitIn (next dividend MSB), divisor;
//        remOut (next partial remainder), qBit (quotient bit produced).
module div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] remIn,
  input  logic         bitIn,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] remOut,
  output logic         qBit
);

  logic [N:0]   shifted;
  logic [N+1:0] trial;
  logic         borrow;

  // The shifted remainder can reach N+1 bits, so the trial difference is
  // carried at N+2 bits to keep the borrow out of the magnitude.
  assign shifted = {remIn, bitIn};
  assign trial   = {1'b0, shifted} - {2'b00, divisor};
  assign borrow  = trial[N+1];

  // On borrow the restored value is below the divisor, so it fits in N bits;
  // without borrow the difference is below the divisor as well.
  assign qBit   = ~borrow;
  assign remOut = borrow ? shifted[N-1:0] : trial[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider producing one quotient bit per cycle.
// Latency: out_valid rises N cycles after the accept edge (same edge for divide-by-zero).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, rst (async active-high); in_valid/in_ready with dividend, divisor;
//        out_valid/out_ready with quotient, remainder, div_by_zero; busy.
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         busy
);

  localparam int CntW = $clog2(N);

  div_state_t    state;
  logic [CntW-1:0] cnt;
  logic [N-1:0]  remWork;     // partial remainder R
  logic [N-1:0]  quoWork;     // dividend bits still to shift out, quotient bits shifted in
  logic [N-1:0]  divReg;      // latched divisor magnitude
  logic [N-1:0]  stepRem;
  logic          stepQ;
  logic [N-1:0]  rawQ;
  logic [N-1:0]  finalQ;
  logic [N-1:0]  finalR;
  logic [N-1:0]  acceptDividend;
  logic [N-1:0]  acceptDivisor;

  div_step #(.N(N)) uStep (
    .remIn  (remWork),
    .bitIn  (quoWork[N-1]),
    .divisor(divReg),
    .remOut (stepRem),
    .qBit   (stepQ)
  );

  // Quotient as it stands after the current step completes.
  assign rawQ = {quoWork[N-2:0], stepQ};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic negQ;
  logic negR;

  // Work on magnitudes; the most-negative value maps to itself, which is
  // still correct read as unsigned.
  assign acceptDividend = dividend[N-1] ? -dividend : dividend;
  assign acceptDivisor  = divisor[N-1]  ? -divisor  : divisor;

  // Quotient negated when signs differ, remainder follows the dividend sign.
  assign finalQ = negQ ? -rawQ : rawQ;
  assign finalR = negR ? -stepRem : stepRem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      negQ <= 1'b0;
      negR <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      negQ <= dividend[N-1] ^ divisor[N-1];
      negR <= dividend[N-1];
    end
  end
`else
  assign acceptDividend = dividend;
  assign acceptDivisor  = divisor;
  assign finalQ         = rawQ;
  assign finalR         = stepRem;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      remWork     <= '0;
      quoWork     <= '0;
      divReg      <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (divisor == '0) begin
              // Skip the iteration entirely; the raw dividend is the remainder.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              remWork <= '0;
              quoWork <= acceptDividend;
              divReg  <= acceptDivisor;
              cnt     <= CntW'(N - 1);
              state   <= DIVIDE;
            end
          end
        end

        DIVIDE: begin
          remWork <= stepRem;
          quoWork <= rawQ;
          if (cnt == '0) begin
            quotient    <= finalQ;
            remainder   <= finalR;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reset state, latency, divide-by-zero,
// output hold under backpressure, mid-operation reset and signed cases.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int lat;

  seq_divider #(.N(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present operands for one cycle, then scramble the bus and wait for out_valid.
  // lat counts clock edges from the accept edge (accept edge = 1).
  task automatic runOp(input logic [31:0] a, input logic [31:0] b, output int latency);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    latency = 1;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 32'hA5A5_5A5A;
    divisor  = 32'h0000_0000;
    while (!out_valid && latency < 200) begin
      @(posedge clk);
      latency++;
      @(negedge clk);
    end
  endtask

  task automatic takeResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 100 / 7
    runOp(32'd100, 32'd7, lat);
    check("t1_latency", lat, 32'd33);
    check("t1_quotient", quotient, 32'd14);
    check("t1_remainder", remainder, 32'd2);
    check("t1_dbz", {31'b0, div_by_zero}, 32'd0);
    check("t1_busy", {31'b0, busy}, 32'd1);
    takeResult("t1");

    // all ones / 1
    runOp(32'hFFFF_FFFF, 32'd1, lat);
    check("t2_quotient", quotient, 32'hFFFF_FFFF);
    check("t2_remainder", remainder, 32'd0);
    takeResult("t2");

    // 5 / 9
    runOp(32'd5, 32'd9, lat);
    check("t3_quotient", quotient, 32'd0);
    check("t3_remainder", remainder, 32'd5);
    takeResult("t3");

    // 1543 / 0
    runOp(32'd1543, 32'd0, lat);
    check("t4_latency", lat, 32'd1);
    check("t4_quotient", quotient, 32'hFFFF_FFFF);
    check("t4_remainder", remainder, 32'd1543);
    check("t4_dbz", {31'b0, div_by_zero}, 32'd1);
    takeResult("t4");

    // 180 / 23 held under backpressure for 10 cycles
    runOp(32'd180, 32'd23, lat);
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", {31'b0, out_valid}, 32'd1);
      check("t5_hold_quotient", quotient, 32'd7);
      check("t5_hold_remainder", remainder, 32'd19);
      check("t5_hold_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    takeResult("t5");
    check("t5_busy_after", {31'b0, busy}, 32'd0);

    // 267 / 2 aborted by reset on cycle 15
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'd267;
    divisor  = 32'd2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("t6_busy_mid", {31'b0, busy}, 32'd1);
    repeat (13) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_out_valid", {31'b0, out_valid}, 32'd0);
    check("t6_in_ready", {31'b0, in_ready}, 32'd1);
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_quotient", quotient, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    runOp(32'd14, 32'd2, lat);
    check("t7_latency", lat, 32'd33);
    check("t7_quotient", quotient, 32'd7);
    check("t7_remainder", remainder, 32'd0);
    takeResult("t7");

`ifdef SEQ_DIVIDER_SIGNED_EN
    // -7 / 2
    runOp(32'hFFFF_FFF9, 32'd2, lat);
    check("s1_quotient", quotient, 32'hFFFF_FFFD);
    check("s1_remainder", remainder, 32'hFFFF_FFFF);
    takeResult("s1");

    // most-negative / -1
    runOp(32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("s2_quotient", quotient, 32'h8000_0000);
    check("s2_remainder", remainder, 32'd0);
    check("s2_dbz", {31'b0, div_by_zero}, 32'd0);
    takeResult("s2");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
